mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single-ported 256×4 data memory between the 4-bit core's load/store port and a host/debug port. It arbitrates round-robin and stalls the core until its access completes. A read is split into an issue cycle and a return cycle. The block sits between the core (`memWrite`/`adr`/`ReadData`) and the data memory, which has a synchronous read with 1-cycle latency.

## Interface
Parameters:
- `ADDR_W`, 8, memory address width
- `DATA_W`, 4, memory data width

Ports:
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high
- `core_req`  in  1  core requests a memory access (held until `core_stall` drops)
- `core_we`  in  1  1 = store, 0 = load
- `core_adr`  in  ADDR_W  core address
- `core_wd`  in  DATA_W  core store data
- `core_stall`  out  1  core must hold PC and request
- `core_rvalid`  out  1  `core_rd` valid this cycle
- `core_rd`  out  DATA_W  load data (= `mem_rd`)
- `host_req`  in  1  host requests one access; every cycle it is high is a new request
- `host_we`  in  1  host store/load
- `host_adr`  in  ADDR_W  host address
- `host_wd`  in  DATA_W  host store data
- `host_halt`  in  1  debug freeze: core never granted while high
- `host_gnt`  out  1  host access issued this cycle
- `host_rvalid`  out  1  `host_rd` valid this cycle
- `host_rd`  out  DATA_W  load data (= `mem_rd`)
- `mem_we`  out  1  memory write enable
- `mem_adr`  out  ADDR_W  memory address
- `mem_wd`  out  DATA_W  memory write data
- `mem_rd`  in  DATA_W  memory read data, valid the cycle after the address

## Operation
State:
- `prio`: 0 = core favoured, 1 = host favoured.
- Core FSM: `C_IDLE` / `C_RET`.
- `host_rvalid` register.

Core eligibility:
- `core_elig = core_req & ~host_halt & (state == C_IDLE)`.

Grant (combinational):
- If both `core_elig` and `host_req` are high, the winner is the core when `prio` = 0 and the host when `prio` = 1.
- Otherwise the single requester wins.
- With no requester, nothing is granted.

Memory drive:
- `mem_adr` and `mem_wd` come from the winner, or from the core when idle.
- `mem_we = winner_we` when any grant is given, else 0.

Priority update:
- After any grant, `prio` points to the other requester: 1 after a core grant, 0 after a host grant.
- With no grant, `prio` holds.

Core FSM:
- `C_IDLE`, core granted store: write commits at this edge. `core_stall` = 0 this cycle, so the core advances. Stay in `C_IDLE`.
- `C_IDLE`, core granted load: `core_stall` = 1. Go to `C_RET`.
- `C_IDLE`, core not granted with `core_req` high: `core_stall` = 1. Stay in `C_IDLE`.
- `C_RET`: `core_rvalid` = 1 and `core_stall` = 0, so the core consumes `core_rd` and advances. The still-asserted `core_req` is ignored, so no re-grant. Always return to `C_IDLE`. The host may be granted in this cycle.

Summary:
- `core_stall = core_req & ~(core store granted) & (state != C_RET)`.
- `host_rvalid` is registered: `host_gnt & ~host_we`.

`host_halt`:
- Blocks new core grants only.
- A core load already in `C_RET` still completes.

Reset:
- `prio` = 0, state = `C_IDLE`, `host_rvalid` = 0.
- While `reset` is high: `mem_we` = 0, `host_gnt` = 0, `core_stall` = 0, `core_rvalid` = 0.
- `core_rd` / `host_rd` follow `mem_rd` and are meaningful only when the matching rvalid is high.
- Reset mid-read drops the pending return; no rvalid is produced after reset.

## Timing
- Store latency: committed at the edge ending the grant cycle. Core store with no conflict takes 1 cycle, 0 stall.
- Load latency: address in cycle N, data plus rvalid in N+1.
  - Core load with no conflict: 2 cycles, 1 stall cycle.
  - Each lost arbitration adds 1 cycle.
- Host may issue back-to-back every cycle when uncontested. `host_rvalid` always follows `host_gnt` (load) by exactly 1 cycle.
- Worst-case core wait under continuous host requests: 1 cycle, because round-robin alternates grants.
- Same address, same cycle: only the winner accesses. Loser sees the winner's write on its own later access.
- No combinational path from `mem_rd` to any control output.

## Test plan
- After reset, core load from adr 0x10, memory holds 0x7. Expect `mem_adr` = 0x10, `mem_we` = 0, `core_stall` = 1 in N; `core_rvalid` = 1, `core_rd` = 0x7, `core_stall` = 0 in N+1; no second grant in N+1.
- Core store 0xA to 0x20 and host store 0x5 to 0x21 in the same cycle with `prio` = 0. Expect the core granted first (no stall), the host granted next cycle, then memory[0x20] = 0xA and memory[0x21] = 0x5.
- Host holds `host_req` continuously doing loads; core issues 3 stores. Expect grants alternating core/host, each core store stalled at most 1 cycle, `host_rvalid` one cycle after each host load grant.
- `host_halt` = 1 with `core_req` held for 5 cycles. Expect `core_stall` = 1 throughout and no core `mem_we`. Release: core granted the next cycle.
- Core load in `C_RET` while host issues a load to 0x30 in the same cycle. Expect `core_rvalid` at N+1, host granted at N+1, `host_rvalid` at N+2 with memory[0x30].
- Assert `reset` in the issue cycle of a core load. Expect `core_rvalid` never asserted, `prio` = 0, `mem_we` = 0 during reset.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported synchronous-read data memory between
// the core load/store port and the host/debug port. Arbitration is
// round-robin; core loads take an issue cycle and a return cycle, during
// which the core is stalled until its data comes back.
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_adr,
  input  logic [DATA_W-1:0] core_wd,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rd,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_adr,
  input  logic [DATA_W-1:0] host_wd,
  input  logic              host_halt,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rd,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  typedef enum logic {
    C_IDLE = 1'b0,
    C_RET  = 1'b1
  } coreState_t;

  coreState_t r_state;
  coreState_t w_nextState;
  logic       r_prio;
  logic       r_hostRvalid;
  logic       w_coreElig;
  logic       w_coreGnt;
  logic       w_hostGnt;

  // State register: core FSM, round-robin pointer and the host return flag.
  // Reset drops any pending return so no rvalid appears afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= C_IDLE;
      r_prio       <= 1'b0;
      r_hostRvalid <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_hostRvalid <= w_hostGnt & ~host_we;
      if (w_coreGnt) begin
        r_prio <= 1'b1;
      end else if (w_hostGnt) begin
        r_prio <= 1'b0;
      end
    end
  end

  // Grant, memory drive, stall and next-state logic; grants are suppressed
  // while reset is high so nothing reaches the memory during reset.
  always_comb begin
    w_nextState = r_state;
    w_coreElig  = core_req & ~host_halt & (r_state == C_IDLE) & ~reset;
    w_coreGnt   = w_coreElig & ~(host_req & r_prio);
    w_hostGnt   = host_req & ~reset & ~(w_coreElig & ~r_prio);
    mem_adr     = core_adr;
    mem_wd      = core_wd;
    mem_we      = 1'b0;
    core_stall  = 1'b0;
    core_rvalid = 1'b0;

    if (w_hostGnt) begin
      mem_adr = host_adr;
      mem_wd  = host_wd;
      mem_we  = host_we;
    end else if (w_coreGnt) begin
      mem_we  = core_we;
    end

    case (r_state)
      C_IDLE: begin
        core_stall = core_req & ~(w_coreGnt & core_we) & ~reset;
        if (w_coreGnt && !core_we) begin
          w_nextState = C_RET;
        end
      end
      C_RET: begin
        core_rvalid = 1'b1;
        w_nextState = C_IDLE;
      end
      default: begin
        w_nextState = C_IDLE;
      end
    endcase
  end

  assign host_gnt    = w_hostGnt;
  assign host_rvalid = r_hostRvalid;
  assign core_rd     = mem_rd;
  assign host_rd     = mem_rd;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors against mem_arbiter with a behavioural
// 256x4 synchronous-read memory. Expected read data is queued when the
// access is issued and a separate monitor pops it whenever an rvalid shows.
module tb_mem_arbiter;

  logic       clk;
  logic       reset;
  logic       core_req;
  logic       core_we;
  logic [7:0] core_adr;
  logic [3:0] core_wd;
  logic       core_stall;
  logic       core_rvalid;
  logic [3:0] core_rd;
  logic       host_req;
  logic       host_we;
  logic [7:0] host_adr;
  logic [3:0] host_wd;
  logic       host_halt;
  logic       host_gnt;
  logic       host_rvalid;
  logic [3:0] host_rd;
  logic       mem_we;
  logic [7:0] mem_adr;
  logic [3:0] mem_wd;
  logic [3:0] mem_rd;

  logic [3:0] memArray [256];
  logic [3:0] coreExpQ [$];
  logic [3:0] hostExpQ [$];
  int         checks;
  int         errors;

  typedef struct packed {
    logic       req;
    logic [7:0] adr;
    logic [3:0] wd;
    logic       stall;
    logic       hgnt;
  } rrVec_t;

  rrVec_t rrVec [6];

  mem_arbiter #(.ADDR_W(8), .DATA_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .core_req    (core_req),
    .core_we     (core_we),
    .core_adr    (core_adr),
    .core_wd     (core_wd),
    .core_stall  (core_stall),
    .core_rvalid (core_rvalid),
    .core_rd     (core_rd),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_adr    (host_adr),
    .host_wd     (host_wd),
    .host_halt   (host_halt),
    .host_gnt    (host_gnt),
    .host_rvalid (host_rvalid),
    .host_rd     (host_rd),
    .mem_we      (mem_we),
    .mem_adr     (mem_adr),
    .mem_wd      (mem_wd),
    .mem_rd      (mem_rd)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural data memory: preloaded while reset is high, otherwise a
  // write-enabled store with registered (1-cycle) read of the address.
  always @(posedge clk) begin
    if (reset) begin
      memArray[8'h10] <= 4'h7;
      memArray[8'h30] <= 4'hC;
    end else if (mem_we) begin
      memArray[mem_adr] <= mem_wd;
    end
    mem_rd <= memArray[mem_adr];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic cReq, input logic cWe,
                               input logic [7:0] cAdr, input logic [3:0] cWd,
                               input logic hReq, input logic hWe,
                               input logic [7:0] hAdr, input logic [3:0] hWd,
                               input logic halt);
    @(posedge clk);
    #1;
    core_req  = cReq;
    core_we   = cWe;
    core_adr  = cAdr;
    core_wd   = cWd;
    host_req  = hReq;
    host_we   = hWe;
    host_adr  = hAdr;
    host_wd   = hWd;
    host_halt = halt;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
  endtask

  // Monitor: every rvalid must match the oldest queued expectation; an
  // rvalid with nothing queued is itself an error.
  always @(negedge clk) begin
    if (core_rvalid) begin
      if (coreExpQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL core_rvalid_unexpected: got 1, expected 0");
      end else begin
        checkOutput("core_rd", 32'(core_rd), 32'(coreExpQ.pop_front()));
      end
    end
    if (host_rvalid) begin
      if (hostExpQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL host_rvalid_unexpected: got 1, expected 0");
      end else begin
        checkOutput("host_rd", 32'(host_rd), 32'(hostExpQ.pop_front()));
      end
    end
  end

  // Directed test sequence.
  initial begin
    logic prevHgnt;
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    core_req  = 1'b1;
    core_we   = 1'b1;
    core_adr  = 8'h05;
    core_wd   = 4'h3;
    host_req  = 1'b1;
    host_we   = 1'b1;
    host_adr  = 8'h06;
    host_wd   = 4'h4;
    host_halt = 1'b0;
    rrVec = '{
      '{1'b1, 8'h40, 4'h1, 1'b0, 1'b0},
      '{1'b1, 8'h41, 4'h2, 1'b1, 1'b1},
      '{1'b1, 8'h41, 4'h2, 1'b0, 1'b0},
      '{1'b1, 8'h42, 4'h3, 1'b1, 1'b1},
      '{1'b1, 8'h42, 4'h3, 1'b0, 1'b0},
      '{1'b0, 8'h00, 4'h0, 1'b0, 1'b1}
    };

    // Reset state with both ports requesting stores.
    @(negedge clk);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_host_gnt", 32'(host_gnt), 32'd0);
    checkOutput("rst_core_stall", 32'(core_stall), 32'd0);
    checkOutput("rst_core_rvalid", 32'(core_rvalid), 32'd0);
    checkOutput("rst_host_rvalid", 32'(host_rvalid), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    core_req = 1'b0;
    host_req = 1'b0;

    // Core load from 0x10 (holds 0x7): issue then return.
    applyStimulus(1'b1, 1'b0, 8'h10, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
    coreExpQ.push_back(4'h7);
    @(negedge clk);
    checkOutput("t1_mem_adr", 32'(mem_adr), 32'h10);
    checkOutput("t1_mem_we", 32'(mem_we), 32'd0);
    checkOutput("t1_stall_issue", 32'(core_stall), 32'd1);
    applyStimulus(1'b1, 1'b0, 8'h10, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
    @(negedge clk);
    checkOutput("t1_rvalid", 32'(core_rvalid), 32'd1);
    checkOutput("t1_stall_ret", 32'(core_stall), 32'd0);
    checkOutput("t1_no_regrant_we", 32'(mem_we), 32'd0);

    // Host load from 0x10 alone; also returns the pointer to the core.
    applyStimulus(1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 8'h10, 4'h0, 1'b0);
    hostExpQ.push_back(4'h7);
    @(negedge clk);
    checkOutput("h1_gnt", 32'(host_gnt), 32'd1);
    checkOutput("h1_mem_adr", 32'(mem_adr), 32'h10);
    idleCycle();
    @(negedge clk);
    checkOutput("h1_rvalid", 32'(host_rvalid), 32'd1);
    checkOutput("h1_core_rvalid", 32'(core_rvalid), 32'd0);

    // Simultaneous stores with the pointer favouring the core.
    applyStimulus(1'b1, 1'b1, 8'h20, 4'hA, 1'b1, 1'b1, 8'h21, 4'h5, 1'b0);
    @(negedge clk);
    checkOutput("t2_host_gnt0", 32'(host_gnt), 32'd0);
    checkOutput("t2_core_stall", 32'(core_stall), 32'd0);
    checkOutput("t2_mem_we0", 32'(mem_we), 32'd1);
    checkOutput("t2_mem_adr0", 32'(mem_adr), 32'h20);
    applyStimulus(1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b1, 8'h21, 4'h5, 1'b0);
    @(negedge clk);
    checkOutput("t2_host_gnt1", 32'(host_gnt), 32'd1);
    checkOutput("t2_mem_adr1", 32'(mem_adr), 32'h21);
    checkOutput("t2_mem_wd1", 32'(mem_wd), 32'h5);
    idleCycle();
    @(negedge clk);
    checkOutput("t2_mem20", 32'(memArray[8'h20]), 32'hA);
    checkOutput("t2_mem21", 32'(memArray[8'h21]), 32'h5);

    // Continuous host loads from 0x30 against three core stores.
    prevHgnt = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(rrVec[i].req, 1'b1, rrVec[i].adr, rrVec[i].wd,
                    1'b1, 1'b0, 8'h30, 4'h0, 1'b0);
      if (rrVec[i].hgnt) hostExpQ.push_back(4'hC);
      @(negedge clk);
      checkOutput($sformatf("t3_stall_%0d", i), 32'(core_stall), 32'(rrVec[i].stall));
      checkOutput($sformatf("t3_hgnt_%0d", i), 32'(host_gnt), 32'(rrVec[i].hgnt));
      checkOutput($sformatf("t3_hrv_%0d", i), 32'(host_rvalid), 32'(prevHgnt));
      prevHgnt = rrVec[i].hgnt;
    end
    idleCycle();
    @(negedge clk);
    checkOutput("t3_hrv_last", 32'(host_rvalid), 32'd1);
    checkOutput("t3_mem40", 32'(memArray[8'h40]), 32'h1);
    checkOutput("t3_mem41", 32'(memArray[8'h41]), 32'h2);
    checkOutput("t3_mem42", 32'(memArray[8'h42]), 32'h3);

    // Debug halt blocks the core for five cycles, then release.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 8'h50, 4'h9, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1);
      @(negedge clk);
      checkOutput($sformatf("t4_stall_%0d", i), 32'(core_stall), 32'd1);
      checkOutput($sformatf("t4_we_%0d", i), 32'(mem_we), 32'd0);
    end
    applyStimulus(1'b1, 1'b1, 8'h50, 4'h9, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
    @(negedge clk);
    checkOutput("t4_rel_stall", 32'(core_stall), 32'd0);
    checkOutput("t4_rel_we", 32'(mem_we), 32'd1);
    checkOutput("t4_rel_adr", 32'(mem_adr), 32'h50);

    // Core load return cycle shared with a host load to 0x30.
    applyStimulus(1'b1, 1'b0, 8'h10, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
    coreExpQ.push_back(4'h7);
    @(negedge clk);
    checkOutput("t5_stall_issue", 32'(core_stall), 32'd1);
    applyStimulus(1'b1, 1'b0, 8'h10, 4'h0, 1'b1, 1'b0, 8'h30, 4'h0, 1'b0);
    hostExpQ.push_back(4'hC);
    @(negedge clk);
    checkOutput("t5_core_rvalid", 32'(core_rvalid), 32'd1);
    checkOutput("t5_host_gnt", 32'(host_gnt), 32'd1);
    checkOutput("t5_mem_adr", 32'(mem_adr), 32'h30);
    checkOutput("t5_stall_ret", 32'(core_stall), 32'd0);
    idleCycle();
    @(negedge clk);
    checkOutput("t5_host_rvalid", 32'(host_rvalid), 32'd1);
    checkOutput("t5_core_rvalid_off", 32'(core_rvalid), 32'd0);

    // Core store so the pointer favours the host before the reset test.
    applyStimulus(1'b1, 1'b1, 8'h60, 4'hE, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
    @(negedge clk);
    checkOutput("t6_pre_stall", 32'(core_stall), 32'd0);

    // Reset asserted in the issue cycle of a core load.
    applyStimulus(1'b1, 1'b0, 8'h10, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("t6_rst_we", 32'(mem_we), 32'd0);
    checkOutput("t6_rst_stall", 32'(core_stall), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h10, 4'h0, 1'b1, 1'b1, 8'h70, 4'h1, 1'b0);
    @(negedge clk);
    checkOutput("t6_rst_hgnt", 32'(host_gnt), 32'd0);
    checkOutput("t6_rst_rvalid", 32'(core_rvalid), 32'd0);
    checkOutput("t6_rst_we2", 32'(mem_we), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    core_req = 1'b0;
    host_req = 1'b0;
    @(negedge clk);
    checkOutput("t6_post_rvalid", 32'(core_rvalid), 32'd0);
    idleCycle();
    @(negedge clk);
    checkOutput("t6_post_rvalid2", 32'(core_rvalid), 32'd0);

    // Contention after reset: pointer must be back on the core.
    applyStimulus(1'b1, 1'b1, 8'h62, 4'hF, 1'b1, 1'b1, 8'h61, 4'h6, 1'b0);
    @(negedge clk);
    checkOutput("t6_prio_hgnt", 32'(host_gnt), 32'd0);
    checkOutput("t6_prio_stall", 32'(core_stall), 32'd0);
    checkOutput("t6_prio_adr", 32'(mem_adr), 32'h62);
    applyStimulus(1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b1, 8'h61, 4'h6, 1'b0);
    @(negedge clk);
    checkOutput("t6_host_after", 32'(host_gnt), 32'd1);
    idleCycle();
    @(negedge clk);
    checkOutput("t6_mem60", 32'(memArray[8'h60]), 32'hE);
    checkOutput("t6_mem61", 32'(memArray[8'h61]), 32'h6);
    checkOutput("t6_mem62", 32'(memArray[8'h62]), 32'hF);

    // All queued returns must have been seen.
    idleCycle();
    @(negedge clk);
    checkOutput("core_queue_empty", 32'(coreExpQ.size()), 32'd0);
    checkOutput("host_queue_empty", 32'(hostExpQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
